// File: rtl/dac_volume_ramp_if.sv
// Control/status bundle between the DAC register file, the volume ramp and the PWM stage.
// The master drives the target, step and mute; the slave returns the live volume and ramp status.
interface dac_volume_ramp_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  target_wr;
  logic [DATA_WIDTH-1:0] target_data;
  logic [DATA_WIDTH-1:0] ramp_step;
  logic                  mute;
  logic [DATA_WIDTH-1:0] volumen_control;
  logic                  busy;
  logic                  done;

  modport master (
    output target_wr, target_data, ramp_step, mute,
    input  volumen_control, busy, done
  );

  modport slave (
    input  target_wr, target_data, ramp_step, mute,
    output volumen_control, busy, done
  );
endinterface

// File: rtl/dac_volume_ramp.sv
// Steps the PWM volume word toward a software target at a fixed tick rate.
// Volume changes and mute/unmute fade in clamped steps instead of jumping, which avoids audible clicks.
module dac_volume_ramp #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned RAMP_DIV   = 1024,
  parameter int unsigned DIV_WIDTH  = $clog2(RAMP_DIV)
) (
  input  logic            clk,
  input  logic            resetn,
  dac_volume_ramp_if.slave bus
);

  localparam int unsigned SUM_WIDTH = DATA_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    UP   = 2'd1,
    DOWN = 2'd2
  } state_e;

  state_e                 state_q, state_d;
  logic [DATA_WIDTH-1:0]  target_q, target_d;
  logic [DATA_WIDTH-1:0]  current_q, current_d;
  logic [DIV_WIDTH-1:0]   tick_q, tick_d;
  logic                   done_q, done_d;

  logic [DATA_WIDTH-1:0]  eff;
  logic                   tick;
  logic [SUM_WIDTH-1:0]   eff_x;
  logic [SUM_WIDTH-1:0]   sum;
  logic [SUM_WIDTH-1:0]   diff;

  // Next-state: target capture, free-running tick, direction and clamped step.
  always_comb begin
    target_d  = target_q;
    current_d = current_q;
    state_d   = IDLE;
    done_d    = 1'b0;

    if (bus.target_wr) begin
      target_d = bus.target_data;
    end

    eff    = bus.mute ? '0 : target_q;
    tick   = (tick_q == DIV_WIDTH'(RAMP_DIV - 1));
    tick_d = tick ? '0 : tick_q + DIV_WIDTH'(1);

    // One extra bit so an overshooting sum or an underflowing difference is visible before clamping.
    eff_x = {1'b0, eff};
    sum   = {1'b0, current_q} + {1'b0, bus.ramp_step};
    diff  = {1'b0, current_q} - {1'b0, bus.ramp_step};

    if (current_q < eff) begin
      state_d = UP;
    end else if (current_q > eff) begin
      state_d = DOWN;
    end

    if (bus.ramp_step == '0) begin
      current_d = eff;
    end else if (tick && (state_q != IDLE)) begin
      if (current_q < eff) begin
        current_d = (sum > eff_x) ? eff : sum[DATA_WIDTH-1:0];
      end else if (current_q > eff) begin
        current_d = (diff[DATA_WIDTH] || (diff < eff_x)) ? eff : diff[DATA_WIDTH-1:0];
      end
    end

    done_d = (state_q != IDLE) && (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (resetn) begin
      state_q   <= IDLE;
      target_q  <= '0;
      current_q <= '0;
      tick_q    <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      current_q <= current_d;
      tick_q    <= tick_d;
      done_q    <= done_d;
    end
  end

  assign bus.volumen_control = current_q;
  assign bus.busy            = (state_q != IDLE);
  assign bus.done            = done_q;

endmodule

// File: doc/dac_volume_ramp.md
# dac_volume_ramp

Upstream stage of the DAC volume PWM generator: produces the `volumen_control` word that the PWM stage compares against its period counter. Holds a software-written target volume and steps the output toward it at a fixed, programmable rate, so volume changes and mute/unmute fade instead of jumping and the analog volume path does not produce audible clicks. Sits between the Wishbone DAC register file and the PWM stage, in the same clock domain.

## Interface
- `DATA_WIDTH`, 8: width of volume words; must match the PWM stage.
- `RAMP_DIV`, 1024: clock cycles between ramp steps (≥2).
- `DIV_WIDTH`, $clog2(RAMP_DIV): width of the tick divider.

- `clk` in 1: system clock; all logic on rising edge.
- `resetn` in 1: synchronous reset, active-high despite the name (codebase convention); sampled on `clk`.
- `target_wr` in 1: one-cycle write strobe for `target_data`.
- `target_data` in DATA_WIDTH: new target volume, captured when `target_wr`=1.
- `ramp_step` in DATA_WIDTH: increment per tick, static register value; 0 = no ramping (immediate).
- `mute` in 1: level; while 1 the effective target is 0.
- `volumen_control` out DATA_WIDTH: current volume to the PWM stage.
- `busy` out 1: high while ramping (state ≠ IDLE).
- `done` out 1: one-cycle pulse when a ramp completes.

## Operation
- Registers: `target_reg`, `current` (drives `volumen_control`), `tick_cnt`, `state`, `done`.
- `target_wr`: `target_reg <= target_data`, regardless of `mute`.
- Effective target `eff = mute ? 0 : target_reg` (combinational).
- Tick divider: `tick_cnt` free-runs 0..RAMP_DIV-1 and wraps; `tick` = (tick_cnt == RAMP_DIV-1). It is never restarted by writes or mute.
- FSM states: IDLE, UP, DOWN. Each cycle, `state <= (current < eff) ? UP : (current > eff) ? DOWN : IDLE`. Any transition is legal, including UP↔DOWN when a new target or mute reverses direction mid-ramp.
- Step, when `ramp_step` ≠ 0, applied only on a `tick` cycle with state UP or DOWN. The direction is re-evaluated from the live `current` vs `eff`, not from the registered state:
  - `current < eff`: `current <= min(current + ramp_step, eff)`.
  - `current > eff`: `current <= max(current - ramp_step, eff)`.
  - `current == eff`: hold.
- Arithmetic is DATA_WIDTH+1 bits. The sum/difference is clamped to `eff`, so the output never overshoots, wraps, or underflows.
- `ramp_step` == 0: `current <= eff` every cycle, independent of tick and state.
- `done` is registered: it asserts on the edge where `state` goes from UP/DOWN to IDLE, and is high for exactly one cycle. A reversal (UP↔DOWN) produces no `done`.
- `busy` = (state ≠ IDLE), combinational from the state register.

## Timing
- Reset (`resetn`=1 at an edge): `volumen_control`=0, `target_reg`=0, `tick_cnt`=0, state=IDLE, `busy`=0, `done`=0. Reset overrides `target_wr` in the same cycle. Reset mid-ramp aborts it with no `done` pulse.
- `target_wr` in cycle T: `target_reg` is valid at T+1; `busy` rises at T+2; the first step lands on the first tick edge at or after the end of cycle T+2.
- When a write coincides with a tick, that tick uses the old target.
- `mute` rising or falling in cycle T: `eff` changes in T, and `busy` rises at T+1 if `current` ≠ new `eff`.
- Last step at edge E (`current` == `eff` from E): state=IDLE and `done`=1 in the cycle after E; `done` drops one cycle later.
- Output changes at most once per RAMP_DIV cycles when `ramp_step` ≠ 0. The PWM stage samples it asynchronously to its period, which is accepted.

## Test plan
- Reset: hold `resetn` 3 cycles mid-activity -> `volumen_control`=0, `busy`=0, `done`=0 in the cycle after the first reset edge; no `done` afterwards.
- Up-ramp: RAMP_DIV=4, `ramp_step`=16, write 64 from 0 -> output 16, 32, 48, 64 on successive ticks 4 cycles apart; `busy` high throughout; single `done` pulse after 64.
- Clamp: `ramp_step`=50, write 120, then write 10 -> output 50, 100, 120, then 70, 20, 10; never exceeds 120 or goes below 10.
- Mute mid-ramp: ramp toward 200 with step 20; assert `mute` at output 100 -> output ramps down 80 … 0 (no `done` at reversal, `done` at 0). Write 40 while muted -> output stays 0. Release `mute` -> ramp up to 40.
- Immediate: `ramp_step`=0, write 0xAB at T -> `volumen_control`=0xAB at T+2; `busy` high only at T+2; `done` at T+3.
- Saturation edges: DATA_WIDTH=8, step 0xFF, target 0xFF from 0 -> single step to 0xFF. Then target 0 -> single step to 0x00 with no wrap.
